// File: rtl/cmplx_mul_seq_pkg.sv
// Shared types and constants for the sequential complex multiplier.
package cmplx_mul_pkg;

  localparam int DATA_W = 16;
  localparam int PROD_W = 32;
  localparam int OUT_W  = 33;
  localparam int NUM_PP = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's complement magnitude; -32768 maps to 0x8000, which is exact as unsigned.
  function automatic logic [DATA_W-1:0] mag16(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 16'd1) : x;
  endfunction

endpackage

// File: rtl/cmplx_mul_seq_vedic16.sv
// Unsigned 16x16 multiplier built Vedic-style from four 8x8 vertical/crosswise
// partial products. Purely combinational.
module vedic16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [15:0] p_ll;
  logic [15:0] p_lh;
  logic [15:0] p_hl;
  logic [15:0] p_hh;

  assign p_ll = {8'd0, a[7:0]}  * {8'd0, b[7:0]};
  assign p_lh = {8'd0, a[7:0]}  * {8'd0, b[15:8]};
  assign p_hl = {8'd0, a[15:8]} * {8'd0, b[7:0]};
  assign p_hh = {8'd0, a[15:8]} * {8'd0, b[15:8]};

  // Combine vertical (ll, hh) and crosswise (lh, hl) terms at their weights.
  assign p = {16'd0, p_ll}
           + {8'd0, p_lh, 8'd0}
           + {8'd0, p_hl, 8'd0}
           + {p_hh, 16'd0};

endmodule

// File: rtl/cmplx_mul_seq.sv
// Sequential signed complex multiplier: one shared unsigned vedic16 array is
// time-multiplexed over the four partial products, with signs applied around it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// in_ready is high only in IDLE; out_valid is high only in DONE and the result
// holds until out_ready is seen high at an edge.
module cmplx_mul_seq #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_im,
  input  logic [DATA_W-1:0] b_re,
  input  logic [DATA_W-1:0] b_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_re,
  output logic [OUT_W-1:0]  out_im,
  output logic [1:0]        dbg_state
);

  import cmplx_mul_pkg::*;

  generate
    if (DATA_W != 16 || OUT_W != 33) begin : g_bad_width
      $error("cmplx_mul_seq supports only DATA_W=16, OUT_W=33");
    end
  endgenerate

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] mag_ar, mag_ai, mag_br, mag_bi;
  logic        sgn_ar, sgn_ai, sgn_br, sgn_bi;
  logic [32:0] acc_re, acc_im;

  logic [15:0] op_a, op_b;
  logic        pp_sign;
  logic        pp_neg;
  logic [31:0] prod;
  logic [32:0] prod_ext;
  logic [32:0] term;

  // Operand-select mux: picks the magnitude pair and product sign for this idx.
  always_comb begin
    op_a    = mag_ar;
    op_b    = mag_br;
    pp_sign = sgn_ar ^ sgn_br;
    case (idx)
      2'd0: begin op_a = mag_ar; op_b = mag_br; pp_sign = sgn_ar ^ sgn_br; end
      2'd1: begin op_a = mag_ai; op_b = mag_bi; pp_sign = sgn_ai ^ sgn_bi; end
      2'd2: begin op_a = mag_ar; op_b = mag_bi; pp_sign = sgn_ar ^ sgn_bi; end
      default: begin op_a = mag_ai; op_b = mag_br; pp_sign = sgn_ai ^ sgn_br; end
    endcase
  end

  vedic16 u_vedic (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  // Sign-apply: idx1 is subtracted from the real part, so its sign is inverted.
  always_comb begin
    prod_ext = {1'b0, prod};
    pp_neg   = pp_sign ^ (idx == 2'd1);
    term     = pp_neg ? (~prod_ext + 33'd1) : prod_ext;
  end

  // Control FSM, operand capture and accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= 2'd0;
      acc_re <= '0;
      acc_im <= '0;
      mag_ar <= '0;
      mag_ai <= '0;
      mag_br <= '0;
      mag_bi <= '0;
      sgn_ar <= 1'b0;
      sgn_ai <= 1'b0;
      sgn_br <= 1'b0;
      sgn_bi <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_ar <= mag16(a_re);
            mag_ai <= mag16(a_im);
            mag_br <= mag16(b_re);
            mag_bi <= mag16(b_im);
            sgn_ar <= a_re[15];
            sgn_ai <= a_im[15];
            sgn_br <= b_re[15];
            sgn_bi <= b_im[15];
            acc_re <= '0;
            acc_im <= '0;
            idx    <= 2'd0;
            state  <= MUL;
          end
        end
        MUL: begin
          if (idx < 2'd2) acc_re <= acc_re + term;
          else            acc_im <= acc_im + term;
          idx <= idx + 2'd1;
          if (idx == 2'(NUM_PP - 1)) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_re    = (state == DONE) ? acc_re : '0;
  assign out_im    = (state == DONE) ? acc_im : '0;
  assign dbg_state = state;

endmodule

// File: tb/tb_cmplx_mul_seq.sv
// Bench for cmplx_mul_seq: directed vector table, backpressure and mid-op reset
// sequences, then random transactions with a scoreboard queue.
module tb_cmplx_mul_seq;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [15:0]        a_re, a_im, b_re, b_im;
  logic               out_valid;
  logic               out_ready;
  logic signed [32:0] out_re, out_im;
  logic [1:0]         dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int n_seen  = 0;
  logic mon_en = 1'b0;
  logic rnd_en = 1'b0;
  logic [65:0] exp_q[$];

  typedef struct {
    logic [15:0] ar, ai, br, bi;
    longint      er, ei;
  } vec_t;

  vec_t vecs[10];

  cmplx_mul_seq #(.DATA_W(16), .OUT_W(33)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_re      (a_re),
    .a_im      (a_im),
    .b_re      (b_re),
    .b_im      (b_im),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int ar, input int ai, input int br, input int bi,
                              input longint er, input longint ei);
    vec_t v;
    v.ar = 16'(ar); v.ai = 16'(ai); v.br = 16'(br); v.bi = 16'(bi);
    v.er = er; v.ei = ei;
    return v;
  endfunction

  task automatic scramble_inputs();
    a_re = 16'($urandom_range(0, 65535));
    a_im = 16'($urandom_range(0, 65535));
    b_re = 16'($urandom_range(0, 65535));
    b_im = 16'($urandom_range(0, 65535));
  endtask

  // Called at posedge+1 with the DUT idle; checks latency, pulse width, values.
  task automatic run_vec(input string name, input vec_t v);
    int lat;
    check({name, "_in_ready"}, longint'(in_ready), 1);
    a_re = v.ar; a_im = v.ai; b_re = v.br; b_im = v.bi;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, 4);
    check({name, "_re"}, longint'(out_re), v.er);
    check({name, "_im"}, longint'(out_im), v.ei);
    @(posedge clk); #1;
    check({name, "_pulse"}, longint'(out_valid), 0);
  endtask

  // Scoreboard monitor: each output handshake pops one expected result.
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      logic [65:0] e;
      n_seen++;
      if (exp_q.size() == 0) begin
        check("rnd_duplicate", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rnd_re", longint'(out_re), longint'($signed(e[65:33])));
        check("rnd_im", longint'(out_im), longint'($signed(e[32:0])));
      end
    end
  end

  // Random out_ready stalls during the random phase.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [15:0] hold_re, hold_im;
    int w;
    vecs[0] = mk(3, 4, 5, 6, -9, 38);
    vecs[1] = mk(-32768, -32768, -32768, -32768, 0, 64'sd2147483648);
    vecs[2] = mk(-32768, 0, 32767, 0, -1073709056, 0);
    vecs[3] = mk(1, -1, 1, 1, 2, 0);
    vecs[4] = mk(0, 0, 1234, 5678, 0, 0);
    vecs[5] = mk(-7, 2, 3, -4, -13, 34);
    vecs[6] = mk(32767, 32767, 32767, -32767, 2147352578, 0);
    vecs[7] = mk(100, -200, -300, 400, 50000, 100000);
    vecs[8] = mk(2, 3, 4, -5, 23, 2);
    vecs[9] = mk(-1, -1, -1, -1, 0, 2);

    // Reset block.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_re", longint'(out_re), 0);
    check("rst_out_im", longint'(out_im), 0);
    check("rst_state", longint'(dbg_state), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 10; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Backpressure: (5+6j)(7+8j) = -13+82j held; pending (1+2j)(3+4j) = -5+10j.
    a_re = 16'd5; a_im = 16'd6; b_re = 16'd7; b_im = 16'd8;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a_re = 16'd1; a_im = 16'd2; b_re = 16'd3; b_im = 16'd4;
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    check("bp_latency", w, 4);
    hold_re = 16'(out_re); hold_im = 16'(out_im);
    check("bp_re", longint'(out_re), -13);
    check("bp_im", longint'(out_im), 82);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", longint'(out_valid), 1);
      check("bp_hold_ready", longint'(in_ready), 0);
      check("bp_hold_re", longint'(out_re), -13);
      check("bp_hold_im", longint'(out_im), 82);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_idle_ready", longint'(in_ready), 1);
    check("bp_idle_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    check("bp_accept", longint'(in_ready), 0);
    in_valid = 1'b0;
    scramble_inputs();
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #1; w++; end
    check("bp2_latency", w, 4);
    check("bp2_re", longint'(out_re), -5);
    check("bp2_im", longint'(out_im), 10);
    @(posedge clk); #1;

    // Reset during idx=2, then (2+3j)(4-5j).
    a_re = 16'd9; a_im = 16'd9; b_re = 16'd9; b_im = 16'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_state_mul", longint'(dbg_state), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_ready", longint'(in_ready), 1);
    check("mid_rst_re", longint'(out_re), 0);
    check("mid_rst_im", longint'(out_im), 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_hold_valid", longint'(out_valid), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_valid", longint'(out_valid), 0);
    run_vec("post_rst", vecs[8]);

    // Random transactions with stalls.
    mon_en = 1'b1; rnd_en = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      longint ar, ai, br, bi, er, ei;
      w = 0;
      while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
      if (!in_ready) begin
        check("rnd_in_ready_timeout", 0, 1);
        break;
      end
      scramble_inputs();
      ar = longint'($signed(a_re)); ai = longint'($signed(a_im));
      br = longint'($signed(b_re)); bi = longint'($signed(b_im));
      er = ar * br - ai * bi;
      ei = ar * bi + ai * br;
      exp_q.push_back({33'(er), 33'(ei)});
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      scramble_inputs();
    end
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin @(posedge clk); #1; w++; end
    rnd_en = 1'b0;
    check("rnd_lost", exp_q.size(), 0);
    check("rnd_count", n_seen, 1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
